srt_r2_divider_core: RTL

//  Sequential radix-2 SRT mantissa divider. Generalises the single-step remainder

---
 rtl/srt_pkg.sv | 34 +++
 rtl/srt_r2_divider_core_if.sv | 26 ++
 rtl/srt_r2_qsel.sv | 14 +
 rtl/srt_r2_divider_core.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/srt_pkg.sv
// Shared types and selection constants for the radix-2 SRT mantissa divider.
// The digit-selection rule lives here so the selector and any reference logic agree.
package srt_pkg;

    typedef enum logic [1:0] {
        QD_ZERO = 2'd0,
        QD_POS  = 2'd1,
        QD_NEG  = 2'd2
    } srt_digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } srt_state_t;

    // Estimate format: sign, 2 integer bits, 2 fraction bits
    localparam logic signed [4:0] EST_POS_TH = 5'sb00100;
    localparam logic signed [4:0] EST_NEG_TH = 5'sb11100;

    function automatic srt_digit_t select_digit(input logic signed [4:0] est);
        srt_digit_t dig;
        if (est >= EST_POS_TH) begin
            dig = QD_POS;
        end else if (est < EST_NEG_TH) begin
            dig = QD_NEG;
        end else begin
            dig = QD_ZERO;
        end
        return dig;
    endfunction

endpackage

// File: rtl/srt_r2_divider_core_if.sv
// Handshake and operand/result bundle of the SRT divider core.
// The master side launches divides; the slave side is the divider itself.
interface srt_r2_divider_core_if #(
    parameter int WIDTH = 24,
    parameter int ITER  = WIDTH + 2
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [ITER-1:0]  quotient;
    logic             sticky;
    logic             err;

    modport master (
        output start, flush, dividend, divisor,
        input  busy, done, quotient, sticky, err
    );

    modport slave (
        input  start, flush, dividend, divisor,
        output busy, done, quotient, sticky, err
    );
endinterface

// File: rtl/srt_r2_qsel.sv
// Radix-2 SRT quotient-digit selector: 5-bit truncated estimate of 2r to a signed digit.
module srt_r2_qsel
    import srt_pkg::*;
(
    input  logic [4:0] est,
    output srt_digit_t digit
);

    // Threshold compare on the two's-complement estimate
    always_comb begin
        digit = select_digit($signed(est));
    end

endmodule

// File: rtl/srt_r2_divider_core.sv
// Sequential radix-2 SRT mantissa divider with on-the-fly Q/QM conversion,
// final negative-remainder correction and sticky generation.
module srt_r2_divider_core
    import srt_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int ITER  = WIDTH + 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    srt_r2_divider_core_if.slave  bus
);

    localparam int RW = WIDTH + 3;
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    srt_state_t       state_r, state_nxt_s;
    logic [RW-1:0]    rem_r, rem_nxt_s;
    logic [RW-1:0]    two_rem_s, d_ext_s, addend_s, rem_step_s, rem_corr_s, rem_fin_s;
    logic             cin_s;
    logic [ITER-1:0]  q_r, q_nxt_s, qm_r, qm_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] div_r, div_nxt_s;
    logic             busy_r, busy_nxt_s, done_r, done_nxt_s;
    logic [ITER-1:0]  quot_r, quot_nxt_s;
    logic             sticky_r, sticky_nxt_s, err_r, err_nxt_s;
    logic             operands_ok_s;
    srt_digit_t       digit_s;

    // Divisor aligned to the remainder format (2 integer bits, WIDTH fraction bits)
    assign d_ext_s       = {2'b00, div_r, 1'b0};
    assign two_rem_s     = {rem_r[RW-2:0], 1'b0};
    assign operands_ok_s = bus.dividend[WIDTH-1] & bus.divisor[WIDTH-1];

    srt_r2_qsel u_qsel (
        .est   (two_rem_s[RW-1:RW-5]),
        .digit (digit_s)
    );

    // Single adder: subtract d as ~d plus carry-in, add d, or pass 2r through
    always_comb begin
        addend_s = {RW{1'b0}};
        cin_s    = 1'b0;
        case (digit_s)
            QD_POS: begin
                addend_s = ~d_ext_s;
                cin_s    = 1'b1;
            end
            QD_NEG:  addend_s = d_ext_s;
            QD_ZERO: addend_s = {RW{1'b0}};
            default: addend_s = {RW{1'b0}};
        endcase
        rem_step_s = two_rem_s + addend_s + {{(RW-1){1'b0}}, cin_s};
        rem_corr_s = rem_r + d_ext_s;
    end

    // Next-state and datapath/output next values
    always_comb begin
        state_nxt_s  = state_r;
        rem_nxt_s    = rem_r;
        q_nxt_s      = q_r;
        qm_nxt_s     = qm_r;
        cnt_nxt_s    = cnt_r;
        div_nxt_s    = div_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        quot_nxt_s   = quot_r;
        sticky_nxt_s = sticky_r;
        err_nxt_s    = err_r;
        rem_fin_s    = rem_r;
        if (bus.flush) begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start && operands_ok_s) begin
                        rem_nxt_s   = {3'b000, bus.dividend};
                        q_nxt_s     = {ITER{1'b0}};
                        qm_nxt_s    = {ITER{1'b0}};
                        cnt_nxt_s   = {CW{1'b0}};
                        div_nxt_s   = bus.divisor;
                        busy_nxt_s  = 1'b1;
                        state_nxt_s = ITERATE;
                    end else if (bus.start) begin
                        quot_nxt_s   = {ITER{1'b0}};
                        sticky_nxt_s = 1'b0;
                        err_nxt_s    = 1'b1;
                        done_nxt_s   = 1'b1;
                        state_nxt_s  = DONE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ITERATE: begin
                    rem_nxt_s = rem_step_s;
                    cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    case (digit_s)
                        QD_POS: begin
                            q_nxt_s  = {q_r[ITER-2:0], 1'b1};
                            qm_nxt_s = {q_r[ITER-2:0], 1'b0};
                        end
                        QD_NEG: begin
                            q_nxt_s  = {qm_r[ITER-2:0], 1'b1};
                            qm_nxt_s = {qm_r[ITER-2:0], 1'b0};
                        end
                        default: begin
                            q_nxt_s  = {q_r[ITER-2:0], 1'b0};
                            qm_nxt_s = {qm_r[ITER-2:0], 1'b1};
                        end
                    endcase
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = CORRECT;
                    end else begin
                        state_nxt_s = ITERATE;
                    end
                end
                CORRECT: begin
                    if (rem_r[RW-1]) begin
                        quot_nxt_s = qm_r;
                        rem_fin_s  = rem_corr_s;
                    end else begin
                        quot_nxt_s = q_r;
                        rem_fin_s  = rem_r;
                    end
                    rem_nxt_s    = rem_fin_s;
                    sticky_nxt_s = |rem_fin_s;
                    err_nxt_s    = 1'b0;
                    busy_nxt_s   = 1'b0;
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = DONE;
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            rem_r    <= {RW{1'b0}};
            q_r      <= {ITER{1'b0}};
            qm_r     <= {ITER{1'b0}};
            cnt_r    <= {CW{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            quot_r   <= {ITER{1'b0}};
            sticky_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rem_r    <= rem_nxt_s;
            q_r      <= q_nxt_s;
            qm_r     <= qm_nxt_s;
            cnt_r    <= cnt_nxt_s;
            div_r    <= div_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            quot_r   <= quot_nxt_s;
            sticky_r <= sticky_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.quotient = quot_r;
    assign bus.sticky   = sticky_r;
    assign bus.err      = err_r;

endmodule
